// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier.
// master = producer of operands and consumer of results; slave = the multiplier.
interface seq_multiplier_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic             signed_mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             overflow;

   modport master (
      output in_valid, signed_mode, a, b, out_ready,
      input  in_ready, out_valid, result_lo, result_hi, overflow
   );

   modport slave (
      input  in_valid, signed_mode, a, b, out_ready,
      output in_ready, out_valid, result_lo, result_hi, overflow
   );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// Signed operands are reduced to magnitudes and the sign is reapplied to the full product.
module seq_multiplier #(
   parameter int WIDTH = 16
) (
   input logic             clk,
   input logic             rst_n,
   seq_multiplier_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [2*WIDTH-1:0] mcand_q,     mcand_d;
   logic [WIDTH-1:0]   mplier_q,    mplier_d;
   logic [2*WIDTH-1:0] acc_q,       acc_d;
   logic               sign_q,      sign_d;
   logic               mode_q,      mode_d;
   logic               in_ready_q,  in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   res_lo_q,    res_lo_d;
   logic [WIDTH-1:0]   res_hi_q,    res_hi_d;
   logic               ovf_q,       ovf_d;

   logic [2*WIDTH-1:0] acc_sum;
   logic [2*WIDTH-1:0] product;

   // The most-negative value maps to 2^(WIDTH-1), still representable as an unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
      return (sm && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   function automatic logic overflow_of(input logic [2*WIDTH-1:0] p, input logic sm);
      if (sm)
         return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
      return p[2*WIDTH-1:WIDTH] != '0;
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      sign_d      = sign_q;
      mode_d      = mode_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      res_lo_d    = res_lo_q;
      res_hi_d    = res_hi_q;
      ovf_d       = ovf_q;
      acc_sum     = acc_q + (mplier_q[0] ? mcand_q : '0);
      product     = sign_q ? (~acc_sum + 1'b1) : acc_sum;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d    = CALC;
               in_ready_d = 1'b0;
               mcand_d    = {{WIDTH{1'b0}}, magnitude(bus.a, bus.signed_mode)};
               mplier_d   = magnitude(bus.b, bus.signed_mode);
               sign_d     = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               mode_d     = bus.signed_mode;
               cnt_d      = '0;
               acc_d      = '0;
            end
         end
         CALC: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // Results are registered on the same edge that leaves CALC.
            if (cnt_q == LAST) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               res_lo_d    = product[WIDTH-1:0];
               res_hi_d    = product[2*WIDTH-1:WIDTH];
               ovf_d       = overflow_of(product, mode_q);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         sign_q      <= 1'b0;
         mode_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         res_lo_q    <= '0;
         res_hi_q    <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         sign_q      <= sign_d;
         mode_q      <= mode_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         res_lo_q    <= res_lo_d;
         res_hi_q    <= res_hi_d;
         ovf_q       <= ovf_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result_lo = res_lo_q;
   assign bus.result_hi = res_hi_q;
   assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a WIDTH=16 instance driven through a scoreboard plus a WIDTH=3 instance.
module tb_seq_multiplier;
   logic clk;
   logic rst_n;
   int   cyc;
   int   tests;
   int   fails;

   typedef struct {
      logic [15:0] lo;
      logic [15:0] hi;
      logic        ovf;
   } exp_t;

   exp_t sb[$];

   seq_multiplier_if #(.WIDTH(16)) bus16 ();
   seq_multiplier_if #(.WIDTH(3))  bus3 ();

   seq_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
   seq_multiplier #(.WIDTH(3))  dut3  (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference product from the language's own multiply, independent of shift-add.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sm);
      exp_t               e;
      logic [31:0]        p;
      logic signed [15:0] sa;
      logic signed [15:0] sbv;
      logic signed [31:0] sp;
      if (sm) begin
         sa  = a;
         sbv = b;
         sp  = 32'(sa) * 32'(sbv);
         p   = sp;
      end else begin
         p = 32'(a) * 32'(b);
      end
      e.lo  = p[15:0];
      e.hi  = p[31:16];
      e.ovf = sm ? (e.hi != {16{e.lo[15]}}) : (e.hi != 16'h0);
      return e;
   endfunction

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sm);
      int guard;
      guard = 0;
      while (bus16.in_ready !== 1'b1 && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 40) begin
         tests++; fails++;
         $display("FAIL issue_ready: in_ready=%b required 1", bus16.in_ready);
      end
      bus16.a           = a;
      bus16.b           = b;
      bus16.signed_mode = sm;
      bus16.in_valid    = 1'b1;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      sb.push_back(model(a, b, sm));
   endtask

   // Waits for the result (junk driven on inputs for the first junk cycles), pops and compares, accepts.
   task automatic collect(input int junk, input string tag);
      int   n;
      exp_t e;
      n = 0;
      while (bus16.out_valid !== 1'b1 && n < 40) begin
         if (n < junk) begin
            bus16.in_valid    = 1'b1;
            bus16.out_ready   = 1'b1;
            bus16.a           = 16'($urandom);
            bus16.b           = 16'($urandom);
            bus16.signed_mode = 1'($urandom);
         end else begin
            bus16.in_valid  = 1'b0;
            bus16.out_ready = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b0;
      tests++;
      if (n !== 16) begin
         fails++;
         $display("FAIL %s_latency: got %0d cycles required 16", tag, n);
      end
      e = '{lo: 16'h0, hi: 16'h0, ovf: 1'b0};
      if (sb.size() > 0) e = sb.pop_front();
      tests++;
      if (bus16.result_lo !== e.lo || bus16.result_hi !== e.hi || bus16.overflow !== e.ovf) begin
         fails++;
         $display("FAIL %s_result: got lo=%h hi=%h ovf=%b required lo=%h hi=%h ovf=%b",
                  tag, bus16.result_lo, bus16.result_hi, bus16.overflow, e.lo, e.hi, e.ovf);
      end
      bus16.out_ready = 1'b1;
      @(posedge clk); #1;
      bus16.out_ready = 1'b0;
      tests++;
      if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s_accept: got out_valid=%b in_ready=%b required 0/1",
                  tag, bus16.out_valid, bus16.in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.result_lo !== 16'h0 ||
          bus16.result_hi !== 16'h0 || bus16.overflow !== 1'b0) begin
         fails++;
         $display("FAIL reset16: got rdy=%b vld=%b lo=%h hi=%h ovf=%b required 1 0 0 0 0",
                  bus16.in_ready, bus16.out_valid, bus16.result_lo, bus16.result_hi, bus16.overflow);
      end
      tests++;
      if (bus3.in_ready !== 1'b1 || bus3.out_valid !== 1'b0 || bus3.result_lo !== 3'h0 ||
          bus3.result_hi !== 3'h0 || bus3.overflow !== 1'b0) begin
         fails++;
         $display("FAIL reset3: got rdy=%b vld=%b lo=%h hi=%h ovf=%b required 1 0 0 0 0",
                  bus3.in_ready, bus3.out_valid, bus3.result_lo, bus3.result_hi, bus3.overflow);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_width3();
      logic [2:0] av [2];
      logic [2:0] bv [2];
      logic [2:0] elo [2];
      logic [2:0] ehi [2];
      logic       eov [2];
      int         n;
      av = '{3'd7, 3'd2}; bv = '{3'd7, 3'd3};
      elo = '{3'd1, 3'd6}; ehi = '{3'd6, 3'd0}; eov = '{1'b1, 1'b0};
      for (int k = 0; k < 2; k++) begin
         bus3.a = av[k]; bus3.b = bv[k]; bus3.signed_mode = 1'b0; bus3.in_valid = 1'b1;
         @(posedge clk); #1;
         bus3.in_valid = 1'b0;
         n = 0;
         while (bus3.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         tests++;
         if (n !== 3 || bus3.result_lo !== elo[k] || bus3.result_hi !== ehi[k] || bus3.overflow !== eov[k]) begin
            fails++;
            $display("FAIL w3_op%0d: got cycles=%0d lo=%0d hi=%0d ovf=%b required 3 %0d %0d %b",
                     k, n, bus3.result_lo, bus3.result_hi, bus3.overflow, elo[k], ehi[k], eov[k]);
         end
         bus3.out_ready = 1'b1;
         @(posedge clk); #1;
         bus3.out_ready = 1'b0;
      end
   endtask

   task automatic test_unsigned();
      issue(16'hFFFF, 16'hFFFF, 1'b0); collect(0, "u_ffff");
      issue(16'd300,  16'd200,  1'b0); collect(6, "u_300x200_noise");
      issue(16'h0000, 16'h1234, 1'b0); collect(0, "u_zero");
      issue(16'hABCD, 16'h0001, 1'b0); collect(0, "u_by_one");
   endtask

   task automatic test_signed();
      issue(16'hFFFD, 16'd5,    1'b1); collect(0, "s_m3x5");
      issue(16'h8000, 16'hFFFF, 1'b1); collect(0, "s_min_x_m1");
      issue(16'h8000, 16'h8000, 1'b1); collect(0, "s_min_x_min");
      issue(16'hFFFF, 16'hFFFF, 1'b1); collect(0, "s_m1_x_m1");
      issue(16'h0000, 16'h8000, 1'b1); collect(0, "s_zero");
      issue(16'h7FFF, 16'h8001, 1'b1); collect(0, "s_max_x_negmax");
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   n;
      issue(16'd1234, 16'd5678, 1'b0);
      n = 0;
      while (bus16.out_valid !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      e = sb.pop_front();
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            bus16.a = 16'd2; bus16.b = 16'd2; bus16.signed_mode = 1'b0; bus16.in_valid = 1'b1;
         end else begin
            bus16.in_valid = 1'b0;
         end
         tests++;
         if (bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0 || bus16.result_lo !== e.lo ||
             bus16.result_hi !== e.hi || bus16.overflow !== e.ovf) begin
            fails++;
            $display("FAIL hold%0d: got vld=%b rdy=%b lo=%h hi=%h ovf=%b required 1 0 %h %h %b",
                     i, bus16.out_valid, bus16.in_ready, bus16.result_lo, bus16.result_hi,
                     bus16.overflow, e.lo, e.hi, e.ovf);
         end
         @(posedge clk); #1;
      end
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b1;
      @(posedge clk); #1;
      bus16.out_ready = 1'b0;
      tests++;
      if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.result_lo !== e.lo) begin
         fails++;
         $display("FAIL release: got rdy=%b vld=%b lo=%h required 1 0 %h",
                  bus16.in_ready, bus16.out_valid, bus16.result_lo, e.lo);
      end
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) n++;
      end
      tests++;
      if (n !== 0) begin
         fails++;
         $display("FAIL ignored_pulse: got %0d busy cycles required 0", n);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      issue(16'd9, 16'd9, 1'b0);
      sb.delete();
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      tests++;
      if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.result_lo !== 16'h0 ||
          bus16.result_hi !== 16'h0 || bus16.overflow !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset: got rdy=%b vld=%b lo=%h hi=%h ovf=%b required 1 0 0 0 0",
                  bus16.in_ready, bus16.out_valid, bus16.result_lo, bus16.result_hi, bus16.overflow);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (bus16.out_valid !== 1'b0) n++;
      end
      tests++;
      if (n !== 0) begin
         fails++;
         $display("FAIL discarded: got %0d out_valid cycles required 0", n);
      end
      issue(16'd4, 16'd4, 1'b0); collect(0, "post_reset_4x4");
   endtask

   task automatic test_back_to_back();
      logic [15:0] a2, b2;
      logic        will_acc;
      int          acc_n, res_n;
      int          acc_t [2];
      exp_t        e;
      acc_n = 0; res_n = 0; acc_t = '{0, 0};
      a2 = 16'hFFF9; b2 = 16'hFFF7;
      bus16.out_ready = 1'b1;
      bus16.a = 16'h1234; bus16.b = 16'h0056; bus16.signed_mode = 1'b0; bus16.in_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         will_acc = bus16.in_valid && bus16.in_ready;
         if (bus16.out_valid === 1'b1) begin
            res_n++;
            e = '{lo: 16'h0, hi: 16'h0, ovf: 1'b0};
            if (sb.size() > 0) e = sb.pop_front();
            tests++;
            if (bus16.result_lo !== e.lo || bus16.result_hi !== e.hi || bus16.overflow !== e.ovf) begin
               fails++;
               $display("FAIL b2b_result%0d: got lo=%h hi=%h ovf=%b required lo=%h hi=%h ovf=%b",
                        res_n, bus16.result_lo, bus16.result_hi, bus16.overflow, e.lo, e.hi, e.ovf);
            end
         end
         @(posedge clk); #1;
         if (will_acc && acc_n < 2) begin
            acc_t[acc_n] = cyc;
            sb.push_back(model(bus16.a, bus16.b, bus16.signed_mode));
            acc_n++;
            if (acc_n == 1) begin
               bus16.a = a2; bus16.b = b2; bus16.signed_mode = 1'b1;
            end else begin
               bus16.in_valid = 1'b0;
            end
         end
      end
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b0;
      tests++;
      if (res_n !== 2) begin
         fails++;
         $display("FAIL b2b_count: got %0d results required 2", res_n);
      end
      tests++;
      if (acc_t[1] - acc_t[0] !== 18) begin
         fails++;
         $display("FAIL b2b_interval: got %0d cycles required 18", acc_t[1] - acc_t[0]);
      end
   endtask

   initial begin
      cyc   = 0;
      tests = 0;
      fails = 0;
      rst_n = 1'b1;
      bus16.in_valid = 1'b0; bus16.signed_mode = 1'b0; bus16.a = '0; bus16.b = '0; bus16.out_ready = 1'b0;
      bus3.in_valid  = 1'b0; bus3.signed_mode  = 1'b0; bus3.a  = '0; bus3.b  = '0; bus3.out_ready  = 1'b0;
      #3;
      test_reset();
      test_width3();
      test_unsigned();
      test_signed();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
